debug_cmd_bridge: RTL and testbench

- Parametrised single-clock debug command bridge for the Nios II debug slave path.
- Takes JTAG-style virtual-state strobes (capture, shift, update-DR, update-IR), already brought into the system clock domain, and runs a DR_W-bit shift register.
- A separate IR register selects one of 2**IR_W command channels.
- On update, issues per-channel take_action requests with a ready handshake, or take_no_action pulses, and flags overruns; the previous fixed 2-bit, 38-bit bridge had neither.

---
 rtl/debug_cmd_bridge.sv | 135 +++++++++++++
 tb/tb_debug_cmd_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_bridge.sv
// Debug command bridge: DR shift register with IR-selected channels, issuing
// per-channel action requests (ready handshake) or no-action pulses on update-DR.
module debug_cmd_bridge #(
  parameter int unsigned  DR_W    = 38,
  parameter int unsigned  IR_W    = 2,
  parameter int unsigned  ACT_BIT = DR_W - 1,
  localparam int unsigned NCH     = 2 ** IR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                capture_en,
  input  logic                shift_en,
  input  logic                tdi,
  output logic                tdo,
  input  logic                update_dr,
  input  logic                update_ir,
  input  logic [IR_W-1:0]     ir_val,
  input  logic [NCH*DR_W-1:0] capture_data,
  output logic [DR_W-1:0]     jdo,
  output logic [IR_W-1:0]     ir_cur,
  output logic [NCH-1:0]      take_action,
  input  logic                act_ready,
  output logic [NCH-1:0]      take_no_action,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_e;

  state_e          state_q, state_d;
  logic [DR_W-1:0] sr_q, sr_d;
  logic [DR_W-1:0] jdo_q, jdo_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [NCH-1:0]  ta_q, ta_d;
  logic [NCH-1:0]  tna_q, tna_d;
  logic            busy_q, busy_d;
  logic            ov_q, ov_d;

  logic            do_cap, do_shift, do_udr;
  logic [DR_W-1:0] cap_word;
  logic [NCH-1:0]  ch_onehot;

  // Fixed strobe priority: update_ir > capture > shift > update_dr.
  assign do_cap    = capture_en & ~update_ir;
  assign do_shift  = shift_en & ~update_ir & ~capture_en;
  assign do_udr    = update_dr & ~update_ir & ~capture_en & ~shift_en;
  assign cap_word  = capture_data[ir_q*DR_W +: DR_W];
  assign ch_onehot = {{(NCH-1){1'b0}}, 1'b1} << ir_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    jdo_d   = jdo_q;
    ir_d    = ir_q;
    ta_d    = ta_q;
    tna_d   = '0;
    busy_d  = busy_q;
    ov_d    = ov_q;

    if (update_ir) begin
      ir_d = ir_val;
      ov_d = 1'b0;
    end

    if (do_cap) begin
      sr_d = cap_word;
      // Completion poll bit: host sees MSB set while the action is outstanding.
      if (busy_q) sr_d[DR_W-1] = 1'b1;
    end else if (do_shift) begin
      sr_d = {tdi, sr_q[DR_W-1:1]};
    end

    case (state_q)
      IDLE: begin
        if (do_udr) begin
          jdo_d = sr_q;
          if (sr_q[ACT_BIT]) begin
            state_d = PENDING;
            ta_d    = ch_onehot;
            busy_d  = 1'b1;
          end else begin
            tna_d = ch_onehot;
          end
        end
      end
      PENDING: begin
        if (do_udr) ov_d = 1'b1;
        if (act_ready) begin
          state_d = IDLE;
          ta_d    = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        ta_d    = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      jdo_q   <= '0;
      ir_q    <= '0;
      ta_q    <= '0;
      tna_q   <= '0;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      jdo_q   <= jdo_d;
      ir_q    <= ir_d;
      ta_q    <= ta_d;
      tna_q   <= tna_d;
      busy_q  <= busy_d;
      ov_q    <= ov_d;
    end
  end

  assign tdo            = sr_q[0];
  assign jdo            = jdo_q;
  assign ir_cur         = ir_q;
  assign take_action    = ta_q;
  assign take_no_action = tna_q;
  assign busy           = busy_q;
  assign overrun        = ov_q;

endmodule

// File: tb/tb_debug_cmd_bridge.sv
// Scoreboard bench for debug_cmd_bridge: expected values queued as stimulus
// is driven, popped and compared once the DUT has produced the output.
module tb_debug_cmd_bridge;

  localparam int unsigned DR_W = 38;
  localparam int unsigned IR_W = 2;
  localparam int unsigned NCH  = 4;

  logic                clk = 1'b0;
  logic                reset, capture_en, shift_en, tdi, tdo;
  logic                update_dr, update_ir, act_ready, busy, overrun;
  logic [IR_W-1:0]     ir_val, ir_cur;
  logic [NCH*DR_W-1:0] capture_data;
  logic [DR_W-1:0]     jdo;
  logic [NCH-1:0]      take_action, take_no_action;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [63:0] exp_q[$];

  debug_cmd_bridge #(.DR_W(DR_W), .IR_W(IR_W), .ACT_BIT(DR_W-1)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en), .shift_en(shift_en),
    .tdi(tdi), .tdo(tdo), .update_dr(update_dr), .update_ir(update_ir),
    .ir_val(ir_val), .capture_data(capture_data), .jdo(jdo), .ir_cur(ir_cur),
    .take_action(take_action), .act_ready(act_ready),
    .take_no_action(take_no_action), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] got);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %h expected <scoreboard empty>", tag, got);
    end else begin
      chk(tag, got, exp_q.pop_front());
    end
  endtask

  task automatic exp_outs(input logic [NCH-1:0] ta, input logic [NCH-1:0] tna,
                          input logic bsy, input logic ov);
    push(64'(ta)); push(64'(tna)); push(64'(bsy)); push(64'(ov));
  endtask

  task automatic cmp_outs(input string tag);
    pop_chk({tag, ".take_action"},    64'(take_action));
    pop_chk({tag, ".take_no_action"}, 64'(take_no_action));
    pop_chk({tag, ".busy"},           64'(busy));
    pop_chk({tag, ".overrun"},        64'(overrun));
  endtask

  // Inputs change 1 time unit after the edge; outputs sampled at that point too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_word(input logic [DR_W-1:0] w);
    for (int i = 0; i < int'(DR_W); i++) begin
      shift_en = 1'b1; tdi = w[i];
      tick();
    end
    shift_en = 1'b0; tdi = 1'b0;
  endtask

  task automatic set_ir(input logic [IR_W-1:0] v);
    update_ir = 1'b1; ir_val = v;
    tick();
    update_ir = 1'b0;
  endtask

  task automatic pulse_udr();
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
  endtask

  task automatic pulse_ready();
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
  endtask

  // Capture then read DR_W bits from tdo, shifting zeros in behind them.
  task automatic capture_and_read(output logic [DR_W-1:0] w);
    capture_en = 1'b1;
    tick();
    capture_en = 1'b0;
    for (int i = 0; i < int'(DR_W); i++) begin
      w[i] = tdo;
      shift_en = 1'b1; tdi = 1'b0;
      tick();
    end
    shift_en = 1'b0;
  endtask

  localparam logic [DR_W-1:0] W1  = 38'h20_0000_00A5;
  localparam logic [DR_W-1:0] W2  = 38'h01_2345_6789;
  localparam logic [DR_W-1:0] W3  = 38'h3F_0000_0011;
  localparam logic [DR_W-1:0] W4  = 38'h12_3456_789A;
  localparam logic [DR_W-1:0] W5  = 38'h2A_AAAA_AAAA;
  localparam logic [DR_W-1:0] WP  = 38'h20_0000_0000;
  localparam logic [DR_W-1:0] CH0 = 38'h00_1234_5678;
  localparam logic [DR_W-1:0] CH1 = 38'h15_5555_5555;
  localparam logic [DR_W-1:0] CH2 = 38'h0A_AAAA_AAAA;
  localparam logic [DR_W-1:0] CH3 = 38'h3F_FFFF_FFFF;

  initial begin
    logic [DR_W-1:0] rd;
    logic [7:0]      lo;
    reset = 1'b1; capture_en = 1'b0; shift_en = 1'b0; tdi = 1'b0;
    update_dr = 1'b0; update_ir = 1'b0; act_ready = 1'b0; ir_val = '0;
    capture_data = {CH3, CH2, CH1, CH0};
    tick(); tick();
    reset = 1'b0;

    // Reset state
    exp_outs('0, '0, 1'b0, 1'b0); push(64'(0)); push(64'(0)); push(64'(0));
    cmp_outs("reset");
    pop_chk("reset.jdo", 64'(jdo));
    pop_chk("reset.ir_cur", 64'(ir_cur));
    pop_chk("reset.tdo", 64'(tdo));

    // Action request on channel 2, held until acknowledged
    set_ir(2'd2);
    push(64'(2)); pop_chk("ir2.ir_cur", 64'(ir_cur));
    shift_word(W1);
    pulse_udr();
    lo = jdo[7:0];
    push(64'h00A5); pop_chk("act.jdo_lo", 64'(lo));
    push(64'(W1));  pop_chk("act.jdo", 64'(jdo));
    exp_outs(4'b0100, '0, 1'b1, 1'b0); cmp_outs("act.issue");
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_outs(4'b0100, '0, 1'b1, 1'b0); cmp_outs("act.hold");
    end
    pulse_ready();
    exp_outs('0, '0, 1'b0, 1'b0); cmp_outs("act.done");

    // No-action pulse on channel 1, exactly one cycle
    set_ir(2'd1);
    shift_word(W2);
    pulse_udr();
    exp_outs('0, 4'b0010, 1'b0, 1'b0); cmp_outs("noact.pulse");
    push(64'(W2)); pop_chk("noact.jdo", 64'(jdo));
    tick();
    exp_outs('0, '0, 1'b0, 1'b0); cmp_outs("noact.after");

    // Overrun: update_dr while pending on channel 3
    set_ir(2'd3);
    shift_word(W3);
    pulse_udr();
    exp_outs(4'b1000, '0, 1'b1, 1'b0); cmp_outs("ovr.issue");
    shift_word(W4);
    pulse_udr();
    push(64'(W3)); pop_chk("ovr.jdo_hold", 64'(jdo));
    exp_outs(4'b1000, '0, 1'b1, 1'b1); cmp_outs("ovr.flag");
    pulse_ready();
    exp_outs('0, '0, 1'b0, 1'b1); cmp_outs("ovr.sticky");
    set_ir(2'd0);
    exp_outs('0, '0, 1'b0, 1'b0); cmp_outs("ovr.clear");

    // Capture channel 0 and serialise out, idle then busy
    capture_and_read(rd);
    push(64'(CH0)); pop_chk("cap.idle", 64'(rd));
    shift_word(WP);
    pulse_udr();
    exp_outs(4'b0001, '0, 1'b1, 1'b0); cmp_outs("cap.pend");
    capture_and_read(rd);
    push(64'(CH0 | WP)); pop_chk("cap.busy", 64'(rd));
    push(64'(1)); pop_chk("cap.busy_bit37", 64'(rd[DR_W-1]));
    push(64'(WP)); pop_chk("cap.jdo_stable", 64'(jdo));
    pulse_ready();
    exp_outs('0, '0, 1'b0, 1'b0); cmp_outs("cap.done");

    // Same-cycle update_ir and update_dr: only the IR changes
    shift_word(W5);
    update_ir = 1'b1; update_dr = 1'b1; ir_val = 2'd3;
    tick();
    update_ir = 1'b0; update_dr = 1'b0;
    push(64'(3)); pop_chk("prio.ir_cur", 64'(ir_cur));
    push(64'(WP)); pop_chk("prio.jdo", 64'(jdo));
    exp_outs('0, '0, 1'b0, 1'b0); cmp_outs("prio.outs");
    tick();
    exp_outs('0, '0, 1'b0, 1'b0); cmp_outs("prio.next");

    // Reset while pending, then a stray acknowledge
    pulse_udr();
    exp_outs(4'b1000, '0, 1'b1, 1'b0); cmp_outs("rst.pend");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_outs('0, '0, 1'b0, 1'b0); cmp_outs("rst.outs");
    push(64'(0)); pop_chk("rst.jdo", 64'(jdo));
    push(64'(0)); pop_chk("rst.ir_cur", 64'(ir_cur));
    pulse_ready();
    exp_outs('0, '0, 1'b0, 1'b0); cmp_outs("rst.stray_ready");

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
